// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that adds CHUNK bits per clock.
// The inter-chunk carry is held in a register, so wide operands need no long
// combinational carry chain.
// Issued with a start/done handshake. Returns the result plus carry,
// signed-overflow and zero flags.
// Optional feature macro: ADDER_SAT_EN. When defined, it adds the 'sat' input,
// which clamps the result on signed overflow.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
`ifdef ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] add_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Index register is at least one bit wide so CHUNK==WIDTH still elaborates.
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Reject chunk sizes that do not tile the operand exactly.
  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("chunked_addsub: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;         // captured operand A
  logic [WIDTH-1:0] b_q;         // captured B, already inverted for subtract
  logic [WIDTH-1:0] res_q;       // working result, filled chunk by chunk
  logic [IDXW-1:0]  idx_q;       // chunk currently being added
  logic             carry_q;     // carry into the current chunk
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] add_out_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;         // {carry, chunk result}
  logic [WIDTH-1:0] res_d;       // working result with this cycle's chunk merged
  logic             ovf_d;
  logic [WIDTH-1:0] final_d;     // value to publish on add_out at completion

  // Select the active chunk, add it, and merge it into the working result.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end

    sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);

    res_d = res_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        res_d[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end
    end

    // Overflow occurs when both effective operands share a sign
    // and the result's sign differs from it.
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);

    final_d = res_d;
`ifdef ADDER_SAT_EN
    // Clamp toward the sign of A. On overflow, A carries the true sign.
    if (sat && ovf_d) begin
      final_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM plus datapath registers. Outputs are updated only at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      add_out_q   <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= Ain;
            b_q     <= sub ? ~Bin : Bin;
            carry_q <= sub;              // +1 completes the two's complement
            idx_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= sum[CHUNK];
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            add_out_q   <= final_d;
            carry_out_q <= sum[CHUNK];
            overflow_q  <= ovf_d;
            zero_q      <= (final_d == '0);
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign add_out   = add_out_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub (32-bit, 8-bit chunks).
// Expected results come from plain wide-integer arithmetic.
module tb_chunked_addsub;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             sat_tb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] add_out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int n_checks = 0;
  int n_err    = 0;

  // Last delivered result; outputs must hold this until the next completion.
  logic [WIDTH-1:0] prev_add;

  chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .Ain       (Ain),
    .Bin       (Bin),
`ifdef ADDER_SAT_EN
    .sat       (sat_tb),
`endif
    .busy      (busy),
    .done      (done),
    .add_out   (add_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic on wide integers, signed range test for overflow.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic sat_en,
                       output logic [31:0] r, output logic c, output logic o,
                       output logic z);
    longint unsigned ua, ub;
    longint sa, sb, sr;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      r  = a + b;
      c  = (ua + ub) > 64'hFFFF_FFFF;
      sr = sa + sb;
    end else begin
      r  = a - b;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    if (sat_en && o) r = sr > 0 ? 32'h7FFF_FFFF : 32'h8000_0000;
    z = (r == 32'h0);
  endtask

  // Assumes start/operands were driven before the coming edge. Waits for done,
  // checks latency, the hold of outputs, and the final result.
  task automatic op_body(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit interfere);
    logic [31:0] er;
    logic ec, eo, ez, sat_en;
    int cnt;
    bit got;
`ifdef ADDER_SAT_EN
    sat_en = sat_tb;
`else
    sat_en = 1'b0;
`endif
    model(a, b, s, sat_en, er, ec, eo, ez);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    cnt = 0;
    got = 0;
    while (cnt < 10 && !got) begin
      if (interfere && cnt == 1) begin
        Ain = $urandom; Bin = $urandom; sub = ~s; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (interfere) begin Ain = $urandom; Bin = $urandom; end
      cnt++;
      if (done) got = 1;
      else begin
        chk("hold_add_out", 64'(add_out), 64'(prev_add));
        chk("busy_running", 64'(busy), 64'd1);
      end
    end
    chk("latency", 64'(cnt), 64'(NCHUNK));
    chk("add_out", 64'(add_out), 64'(er));
    chk("carry_out", 64'(carry_out), 64'(ec));
    chk("overflow", 64'(overflow), 64'(eo));
    chk("zero", 64'(zero), 64'(ez));
    chk("busy_at_done", 64'(busy), 64'd0);
    $display("op %s a=%08h b=%08h -> %08h c=%0b v=%0b z=%0b (exp %08h) lat=%0d",
             s ? "sub" : "add", a, b, add_out, carry_out, overflow, zero, er, cnt);
    prev_add = er;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    Ain = a; Bin = b; sub = s; start = 1'b1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    drive(a, b, s);
    op_body(a, b, s, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; Ain = '0; Bin = '0; sat_tb = 1'b0;
    prev_add = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_add_out", 64'(add_out), 64'd0);
    chk("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(32'd1, 32'd1, 1'b0);
    do_op(32'h0000_FFFF, 32'd1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(32'd5, 32'd7, 1'b1);
    do_op(32'd7, 32'd5, 1'b1);
    do_op(32'd5, 32'd5, 1'b1);
    do_op(32'h8000_0000, 32'd1, 1'b1);
`ifdef ADDER_SAT_EN
    sat_tb = 1'b1;
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b1);
    sat_tb = 1'b0;
`endif

    // start re-pulsed mid-operation with different operands: ignored
    @(negedge clk);
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    op_body(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);

    // Back-to-back: start asserted in the done cycle
    drive(32'hDEAD_BEEF, 32'h0000_0111, 1'b1);
    op_body(32'hDEAD_BEEF, 32'h0000_0111, 1'b1, 1'b0);

    // Reset asserted mid-operation
    @(negedge clk);
    drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_add_out", 64'(add_out), 64'd0);
    chk("abort_flags", 64'({done, carry_out, overflow, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_add = '0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    do_op(32'd4, 32'd8, 1'b0);

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = pick_operand();
      rb = pick_operand();
      rs = 1'($urandom_range(0, 1));
`ifdef ADDER_SAT_EN
      sat_tb = 1'($urandom_range(0, 1));
`endif
      do_op(ra, rb, rs);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
